bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the native memory bus (valid/ready/addr/wdata/wstrb/rdata) in front of the SoC address decoder.
- Master 0 is the CPU. Master 1 is a second requester, e.g. a DMA or debug loader.
- Shares the single slave-side bus with round-robin fairness and holds the grant until the transfer completes.
- A per-transfer watchdog terminates transfers to slaves that never assert ready and reports the address.

Parameters:
- TIMEOUT, 255: cycles a granted transfer may wait for s_ready before forced termination. 0 disables the watchdog.
- CNT_W, 8: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request
- m0_instr  in  1  master 0 instruction fetch flag
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte write strobes (0 = read)
- m0_ready  out  1  master 0 transfer complete
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, with no instr input
- s_valid  out  1  slave-side request
- s_instr  out  1  forwarded m0_instr; 0 when master 1 is granted
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave write strobes
- s_ready  in  1  slave transfer complete
- s_rdata  in  32  slave read data
- timeout_err  out  1  one-cycle pulse on watchdog termination
- err_addr  out  32  address of the last timed-out transfer
- err_master  out  1  master index of the last timed-out transfer

Behaviour:
- State machine states: IDLE, GNT0, GNT1. Reset state is IDLE.
- Reset values: last_grant=1 (so master 0 wins the first tie), counter=0, err_addr=0, err_master=0, timeout_err=0.
- Reset is asynchronous and takes effect mid-transfer. No ready is issued for an interrupted transfer.
- IDLE outputs: s_valid=0; s_addr, s_wdata, s_wstrb, s_instr all 0; m*_ready=0; m*_rdata=0.
- Arbitration in IDLE:
  - only m0_valid -> GNT0; only m1_valid -> GNT1.
  - both -> grant the master that is not last_grant.
  - none -> stay in IDLE.
  - The grant is registered, so s_valid rises the cycle after the request is seen (1 cycle arbitration latency).
- In GNTn:
  - s_valid, s_addr, s_wdata, s_wstrb and s_instr are combinational pass-throughs of master n.
  - mn_ready = s_ready.
  - mn_rdata = s_rdata, valid while mn_ready is high.
  - The other master sees ready=0 and rdata=0.
- Completion: s_ready=1 in GNTn -> next state IDLE, last_grant=n, counter cleared.
  - IDLE always lasts at least one cycle between grants, so s_valid drops for at least one cycle. Slaves whose ready is gated by their own previous ready see a clean edge.
- Abort: mn_valid drops while in GNTn without s_ready -> return to IDLE, no ready, last_grant unchanged, no error.
- Watchdog (TIMEOUT>0):
  - counter increments on each GNTn cycle with s_ready=0.
  - When counter==TIMEOUT-1 and s_ready=0:
    - mn_ready=1 that cycle and mn_rdata=TIMEOUT_RDATA.
    - timeout_err pulses the following cycle.
    - err_addr and err_master are latched.
    - next state IDLE, last_grant=n.
  - s_ready=1 in that same cycle wins: normal completion, no error.
- Writes on timeout: data is discarded. Ready is still returned so the master does not hang.
- err_addr and err_master hold their values until the next timeout or reset.
- Width rules: counter saturates; it never wraps.

Test Plan:
- Single master: m0 reads 0x1000_0010 and the slave answers ready 2 cycles after s_valid with rdata 0x1234_5678 -> s_valid rises 1 cycle after m0_valid; m0_ready is high for 1 cycle with m0_rdata=0x1234_5678; m1_ready stays 0.
- Contention: m0 and m1 both valid from reset, with the slave readying after 1 cycle -> grants in order m0, m1, m0, m1; at least one idle cycle between grants; s_instr=0 during m1 grants.
- Write passthrough: m1 writes 0xA5A5_A5A5 with wstrb=4'b0101 to 0x2000_0000 -> s_wstrb=4'b0101 and s_wdata=0xA5A5_A5A5 for exactly the GNT1 cycles.
- Timeout with TIMEOUT=4: m0 reads 0x6000_0000 and the slave never readies -> m0_ready on the 4th GNT0 cycle with rdata=0xDEAD_BEEF; timeout_err pulses once; err_addr=0x6000_0000, err_master=0.
- Race: s_ready arrives exactly on cycle TIMEOUT-1 -> normal completion with slave data; timeout_err stays 0; err_addr is unchanged.
- resetn asserted mid-GNT1 -> all outputs 0 immediately; after release, simultaneous requests grant m0 first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the native memory bus. A per-transfer
// watchdog force-completes transfers to slaves that never raise s_ready.
module bus_arbiter #(
  parameter int          TIMEOUT       = 255,
  parameter int          CNT_W         = 8,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        timeout_err,
  output logic [31:0] err_addr,
  output logic        err_master
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam bit              LP_WDOG_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] LP_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_lastGrant;
  logic             w_lastGrantNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_timeoutErr;
  logic [31:0]      r_errAddr;
  logic             r_errMaster;

  logic             w_sel;
  logic             w_selValid;
  logic [31:0]      w_selAddr;
  logic [31:0]      w_selWdata;
  logic [3:0]       w_selWstrb;
  logic             w_selReady;
  logic [31:0]      w_selRdata;
  logic             w_timeout;

  // Index of the master currently owning the bus (meaningful only in GNT0/GNT1).
  assign w_sel = (r_state == GNT1);

  always_comb begin
    w_selValid = m0_valid;
    w_selAddr  = m0_addr;
    w_selWdata = m0_wdata;
    w_selWstrb = m0_wstrb;
    if (w_sel) begin
      w_selValid = m1_valid;
      w_selAddr  = m1_addr;
      w_selWdata = m1_wdata;
      w_selWstrb = m1_wstrb;
    end
  end

  // Next-state and output logic. A dropped request takes priority over the
  // watchdog: with nothing outstanding there is no transfer left to terminate.
  always_comb begin
    w_nextState     = r_state;
    w_lastGrantNext = r_lastGrant;
    w_cntNext       = r_cnt;
    w_timeout       = 1'b0;
    w_selReady      = 1'b0;
    w_selRdata      = '0;
    s_valid         = 1'b0;
    s_instr         = 1'b0;
    s_addr          = '0;
    s_wdata         = '0;
    s_wstrb         = '0;
    m0_ready        = 1'b0;
    m0_rdata        = '0;
    m1_ready        = 1'b0;
    m1_rdata        = '0;

    case (r_state)
      IDLE: begin
        w_cntNext = '0;
        if (m0_valid && m1_valid) begin
          w_nextState = r_lastGrant ? GNT0 : GNT1;
        end else if (m0_valid) begin
          w_nextState = GNT0;
        end else if (m1_valid) begin
          w_nextState = GNT1;
        end
      end

      GNT0, GNT1: begin
        s_valid = w_selValid;
        s_instr = w_sel ? 1'b0 : m0_instr;
        s_addr  = w_selAddr;
        s_wdata = w_selWdata;
        s_wstrb = w_selWstrb;

        w_timeout  = LP_WDOG_EN && !s_ready && w_selValid && (r_cnt == LP_CNT_LAST);
        w_selReady = s_ready || w_timeout;
        w_selRdata = w_timeout ? TIMEOUT_RDATA : s_rdata;

        if (w_sel) begin
          m1_ready = w_selReady;
          m1_rdata = w_selRdata;
        end else begin
          m0_ready = w_selReady;
          m0_rdata = w_selRdata;
        end

        if (s_ready || w_timeout) begin
          w_nextState     = IDLE;
          w_lastGrantNext = w_sel;
          w_cntNext       = '0;
        end else if (!w_selValid) begin
          w_nextState = IDLE;
          w_cntNext   = '0;
        end else if (r_cnt != LP_CNT_MAX) begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      default: begin
        w_nextState = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_nextState;
      r_lastGrant <= w_lastGrantNext;
      r_cnt       <= w_cntNext;
    end
  end

  // Error reporting: pulse one cycle after the forced completion and keep the
  // offending address/master until the next timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timeoutErr <= 1'b0;
      r_errAddr    <= '0;
      r_errMaster  <= 1'b0;
    end else begin
      r_timeoutErr <= w_timeout;
      if (w_timeout) begin
        r_errAddr   <= w_selAddr;
        r_errMaster <= w_sel;
      end
    end
  end

  assign timeout_err = r_timeoutErr;
  assign err_addr    = r_errAddr;
  assign err_master  = r_errMaster;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a model.
module tb_bus_arbiter;

  localparam int TO = 4;
  localparam int CW = 3;
  localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        timeout_err, err_master;
  logic [31:0] err_addr;

  int nChecks = 0;
  int nFail   = 0;

  bus_arbiter #(.TIMEOUT(TO), .CNT_W(CW), .TIMEOUT_RDATA(TO_RDATA)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_err(timeout_err), .err_addr(err_addr), .err_master(err_master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who owns the bus, how long it has waited,
  // whose turn it is on a tie, and the error record.
  int          mOwn, mLast, mWait, mErrMaster;
  logic [31:0] mErrAddr;
  logic        mErrPulse;
  logic        mv [2];
  logic [31:0] ma [2], mw [2];
  logic [3:0]  ms [2];
  logic        eR [2];
  logic [31:0] eRd [2];
  logic        eSV, eSI, tNow;
  logic [31:0] eSA, eSW;
  logic [3:0]  eSS;

  always @(negedge clk) begin
    if (!resetn) begin
      mOwn = -1; mLast = 1; mWait = 0; mErrMaster = 0; mErrAddr = '0; mErrPulse = 1'b0;
      checkOutput("rst_s_valid", {31'd0, s_valid}, 32'd0);
      checkOutput("rst_s_addr", s_addr, 32'd0);
      checkOutput("rst_m_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      checkOutput("rst_err_addr", err_addr, 32'd0);
    end else begin
      mv[0] = m0_valid; ma[0] = m0_addr; mw[0] = m0_wdata; ms[0] = m0_wstrb;
      mv[1] = m1_valid; ma[1] = m1_addr; mw[1] = m1_wdata; ms[1] = m1_wstrb;
      eSV = 1'b0; eSI = 1'b0; eSA = '0; eSW = '0; eSS = '0; tNow = 1'b0;
      eR[0] = 1'b0; eR[1] = 1'b0; eRd[0] = '0; eRd[1] = '0;
      if (mOwn >= 0) begin
        eSV = mv[mOwn];
        eSI = (mOwn == 0) ? m0_instr : 1'b0;
        eSA = ma[mOwn]; eSW = mw[mOwn]; eSS = ms[mOwn];
        tNow = !s_ready && mv[mOwn] && (mWait == TO - 1);
        eR[mOwn]  = s_ready || tNow;
        eRd[mOwn] = tNow ? TO_RDATA : s_rdata;
      end
      checkOutput("s_valid", {31'd0, s_valid}, {31'd0, eSV});
      checkOutput("s_instr", {31'd0, s_instr}, {31'd0, eSI});
      checkOutput("s_addr", s_addr, eSA);
      checkOutput("s_wdata", s_wdata, eSW);
      checkOutput("s_wstrb", {28'd0, s_wstrb}, {28'd0, eSS});
      checkOutput("m0_ready", {31'd0, m0_ready}, {31'd0, eR[0]});
      checkOutput("m1_ready", {31'd0, m1_ready}, {31'd0, eR[1]});
      checkOutput("m0_rdata", m0_rdata, eRd[0]);
      checkOutput("m1_rdata", m1_rdata, eRd[1]);
      checkOutput("timeout_err", {31'd0, timeout_err}, {31'd0, mErrPulse});
      checkOutput("err_addr", err_addr, mErrAddr);
      checkOutput("err_master", {31'd0, err_master}, mErrMaster);

      // Advance the model to what the bus looks like after the coming edge.
      mErrPulse = tNow;
      if (mOwn < 0) begin
        mWait = 0;
        if (mv[0] && mv[1]) mOwn = (mLast == 0) ? 1 : 0;
        else if (mv[0])     mOwn = 0;
        else if (mv[1])     mOwn = 1;
      end else if (s_ready) begin
        mLast = mOwn; mOwn = -1; mWait = 0;
      end else if (!mv[mOwn]) begin
        mOwn = -1; mWait = 0;
      end else if (tNow) begin
        mErrAddr = ma[mOwn]; mErrMaster = mOwn; mLast = mOwn; mOwn = -1; mWait = 0;
      end else if (mWait < (1 << CW) - 1) begin
        mWait = mWait + 1;
      end
    end
  end

  logic rdy0, rdy1;

  task automatic applyStimulus(input int cyc);
    if (m0_valid && (rdy0 || $urandom_range(0, 99) < 2)) m0_valid = 1'b0;
    else if (!m0_valid && $urandom_range(0, 99) < 40) begin
      m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom;
      m0_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      m0_instr = 1'($urandom_range(0, 1));
    end
    if (m1_valid && (rdy1 || $urandom_range(0, 99) < 2)) m1_valid = 1'b0;
    else if (!m1_valid && $urandom_range(0, 99) < 40) begin
      m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
      m1_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
    end
    s_ready = ((cyc % 200) < 40) ? 1'b0 : ($urandom_range(0, 99) < 30);
    s_rdata = $urandom;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_time_limit: simulation did not finish, expected completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int  gnt, gotN, got[4];
    bit  done, prevSV, prevRdy, sawIdle, gap[4];

    resetn = 1'b0;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
    #2;
    checkOutput("reset_s_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("reset_err_master", {31'd0, err_master}, 32'd0);
    checkOutput("reset_err_addr", err_addr, 32'd0);
    tick; tick;
    resetn = 1'b1;
    tick;

    // Single master read with a slave answering on the third grant cycle.
    m0_valid = 1; m0_addr = 32'h1000_0010;
    #3 checkOutput("sm_latency_idle", {31'd0, s_valid}, 32'd0);
    tick;
    #3 checkOutput("sm_s_valid", {31'd0, s_valid}, 32'd1);
    checkOutput("sm_s_addr", s_addr, 32'h1000_0010);
    tick;
    tick; s_ready = 1; s_rdata = 32'h1234_5678;
    #3 checkOutput("sm_m0_ready", {31'd0, m0_ready}, 32'd1);
    checkOutput("sm_m0_rdata", m0_rdata, 32'h1234_5678);
    checkOutput("sm_m1_ready", {31'd0, m1_ready}, 32'd0);
    tick; m0_valid = 0; s_ready = 0; s_rdata = 0;
    #3 checkOutput("sm_ready_one_cycle", {31'd0, m0_ready}, 32'd0);

    // Contention from reset: strict alternation, idle gap between grants.
    tick; resetn = 0;
    m0_valid = 1; m0_instr = 1; m0_addr = 32'h1111_0000;
    m1_valid = 1; m1_addr = 32'h2222_0000;
    tick; resetn = 1;
    gotN = 0; prevSV = 0; prevRdy = 0; sawIdle = 1;
    for (int c = 0; c < 40 && gotN < 4; c++) begin
      tick;
      s_ready = prevSV && !prevRdy;
      #3;
      if (!s_valid) sawIdle = 1;
      if (m0_ready || m1_ready) begin
        got[gotN] = m1_ready ? 1 : 0;
        gap[gotN] = sawIdle;
        if (m1_ready) checkOutput("cont_s_instr_m1", {31'd0, s_instr}, 32'd0);
        gotN++;
        sawIdle = 0;
      end
      prevSV = s_valid; prevRdy = s_ready;
    end
    checkOutput("cont_grant_count", gotN, 4);
    for (int k = 0; k < gotN; k++) begin
      checkOutput("cont_grant_order", got[k], k % 2);
      if (k > 0) checkOutput("cont_idle_gap", {31'd0, gap[k]}, 32'd1);
    end
    tick; m0_valid = 0; m1_valid = 0; m0_instr = 0; s_ready = 0;
    tick;

    // Write passthrough from master 1.
    m1_valid = 1; m1_addr = 32'h2000_0000; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0101;
    gnt = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) tick;
      s_ready = (gnt == 2);
      #3;
      if (s_valid) begin
        gnt++;
        checkOutput("wr_s_wstrb", {28'd0, s_wstrb}, 32'h5);
        checkOutput("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
      end else begin
        checkOutput("wr_idle_wstrb", {28'd0, s_wstrb}, 32'h0);
      end
      if (m1_ready) done = 1;
    end
    checkOutput("wr_done", {31'd0, done}, 32'd1);
    checkOutput("wr_grant_cycles", gnt, 3);
    tick; m1_valid = 0; m1_wstrb = 0; m1_wdata = 0; s_ready = 0;
    tick;

    // Watchdog timeout on master 0.
    m0_valid = 1; m0_addr = 32'h6000_0000;
    gnt = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick;
      #3;
      if (s_valid) gnt++;
      if (m0_ready) begin
        done = 1;
        checkOutput("to_grant_cycle", gnt, 4);
        checkOutput("to_rdata", m0_rdata, 32'hDEAD_BEEF);
      end
    end
    checkOutput("to_done", {31'd0, done}, 32'd1);
    tick; m0_valid = 0;
    #3 checkOutput("to_err_pulse", {31'd0, timeout_err}, 32'd1);
    checkOutput("to_err_addr", err_addr, 32'h6000_0000);
    checkOutput("to_err_master", {31'd0, err_master}, 32'd0);
    tick;
    #3 checkOutput("to_err_single", {31'd0, timeout_err}, 32'd0);

    // Slave answers on the last watchdog cycle: ready wins, no error.
    m1_valid = 1; m1_addr = 32'h7000_0000; s_rdata = 32'h0BAD_F00D;
    gnt = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick;
      s_ready = (gnt == 3);
      #3;
      if (s_valid) gnt++;
      if (m1_ready) begin
        done = 1;
        checkOutput("race_grant_cycle", gnt, 4);
        checkOutput("race_rdata", m1_rdata, 32'h0BAD_F00D);
      end
    end
    checkOutput("race_done", {31'd0, done}, 32'd1);
    tick; m1_valid = 0; s_ready = 0;
    #3 checkOutput("race_no_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("race_err_addr_kept", err_addr, 32'h6000_0000);
    tick;

    // Reset in the middle of a master 1 grant.
    m1_valid = 1; m1_addr = 32'h3000_0000;
    tick;
    #2 checkOutput("mrst_pre_grant", {31'd0, s_valid}, 32'd1);
    #1 resetn = 0;
    #1 checkOutput("mrst_s_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("mrst_s_addr", s_addr, 32'd0);
    checkOutput("mrst_m1_ready", {31'd0, m1_ready}, 32'd0);
    checkOutput("mrst_err_addr", err_addr, 32'd0);
    tick; m0_valid = 1; m0_addr = 32'h4000_0000;
    tick; resetn = 1;
    #3 checkOutput("mrst_idle_after", {31'd0, s_valid}, 32'd0);
    tick; s_ready = 1;
    #3 checkOutput("mrst_m0_first", s_addr, 32'h4000_0000);
    checkOutput("mrst_m0_ready", {31'd0, m0_ready}, 32'd1);
    tick; m0_valid = 0; m1_valid = 0; s_ready = 0;
    tick;

    // Randomized traffic, checked by the model every cycle.
    rdy0 = 0; rdy1 = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      applyStimulus(c);
      #3;
      rdy0 = m0_ready; rdy1 = m1_ready;
    end
    tick; m0_valid = 0; m1_valid = 0; s_ready = 0;
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
